// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared constants for the key event decoder: event codes presented on
//   event_code and the FSM state encodings.
//   Optional feature macro used by the decoder: KEY_REPEAT_EN.
package key_event_pkg;

   localparam logic [2:0] EV_NONE      = 3'd0;
   localparam logic [2:0] EV_PRESS     = 3'd1;
   localparam logic [2:0] EV_REL_SHORT = 3'd2;
   localparam logic [2:0] EV_LONG      = 3'd3;
   localparam logic [2:0] EV_REL_LONG  = 3'd4;
   localparam logic [2:0] EV_REPEAT    = 3'd5;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PRESSED   = 2'd1;
   localparam logic [1:0] ST_LONG_HELD = 2'd2;

endpackage

// File: rtl/key_event_decoder_tick_prescaler.sv
// tick_prescaler
//   Divides sys_clk into a one-cycle timing tick. The counter runs
//   0 .. C_TICK_DIV-1 and tick is high while it sits on the last value.
//   clr restarts the count at 0 so tick timing is relative to the press edge.
// Ports:
//   sys_clk  in   system clock
//   sys_rst  in   asynchronous active-low reset
//   clr      in   synchronous restart of the count
//   tick     out  one-cycle pulse every C_TICK_DIV cycles
module tick_prescaler #(
   parameter int unsigned C_TICK_DIV = 50000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned W = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(C_TICK_DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns a debounced key level into timed key events (PRESS, REL_SHORT,
//   LONG, REL_LONG and, with the optional feature, REPEAT) held in a single
//   entry valid/ready output register.
//   Optional feature macro: KEY_REPEAT_EN (enables REPEAT while long-held).
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   asynchronous active-low reset
//   key_in       in   debounced key level
//   event_valid  out  event pending
//   event_code   out  pending event code (see key_event_pkg)
//   event_ready  in   consumer accepts when event_valid & event_ready
//   key_active   out  registered pressed state
//   overflow     out  sticky, an event was dropped under backpressure
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | key released (or reset while held); waits for press edge
// PRESSED   | key held, counting ticks toward the LONG threshold
// LONG_HELD | LONG emitted; waits for release (optionally REPEATs)
module key_event_decoder
   import key_event_pkg::*;
#(
   parameter logic        C_INPUT_POLARITY = 1'b0,
   parameter int unsigned C_TICK_DIV       = 50000,
   parameter int unsigned C_LONG_TICKS     = 1000,
   parameter int unsigned C_REPEAT_TICKS   = 200,
   parameter int unsigned C_CNT_WIDTH      = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_in,
   output logic       event_valid,
   output logic [2:0] event_code,
   input  logic       event_ready,
   output logic       key_active,
   output logic       overflow
);

   localparam logic [C_CNT_WIDTH-1:0] LONG_TH = C_CNT_WIDTH'(C_LONG_TICKS);
   localparam logic [C_CNT_WIDTH-1:0] REP_TH  = C_CNT_WIDTH'(C_REPEAT_TICKS);

   logic                   key_q, key_d;
   logic                   key_active_q, key_active_d;
   logic [1:0]             state_q, state_d;
   logic [C_CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
   logic                   ev_valid_q, ev_valid_d;
   logic [2:0]             ev_code_q, ev_code_d;
   logic                   overflow_q, overflow_d;

   logic       now_active, prev_active;
   logic       press_edge, rel_edge;
   logic       presc_clr, tick;
   logic       new_ev;
   logic [2:0] new_code;

   assign now_active  = (key_in == C_INPUT_POLARITY);
   assign prev_active = (key_q  == C_INPUT_POLARITY);
   assign press_edge  = !prev_active &&  now_active;
   assign rel_edge    =  prev_active && !now_active;
   assign presc_clr   = press_edge && (state_q == ST_IDLE);

   tick_prescaler #(
      .C_TICK_DIV (C_TICK_DIV)
   ) u_presc (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (presc_clr),
      .tick    (tick)
   );

`ifdef KEY_REPEAT_EN
   logic [C_CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end
`else
   logic [C_CNT_WIDTH-1:0] unused_rep_th;
   assign unused_rep_th = REP_TH;
`endif

   // Release is tested before any threshold so a coincident release wins.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
`ifdef KEY_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
`endif
      new_ev     = 1'b0;
      new_code   = EV_NONE;
      case (state_q)
         ST_IDLE: begin
            if (press_edge) begin
               state_d    = ST_PRESSED;
               hold_cnt_d = '0;
`ifdef KEY_REPEAT_EN
               rep_cnt_d  = '0;
`endif
               new_ev     = 1'b1;
               new_code   = EV_PRESS;
            end
         end
         ST_PRESSED: begin
            if (rel_edge) begin
               state_d  = ST_IDLE;
               new_ev   = 1'b1;
               new_code = EV_REL_SHORT;
            end else if (hold_cnt_q == LONG_TH) begin
               state_d  = ST_LONG_HELD;
               new_ev   = 1'b1;
               new_code = EV_LONG;
            end else if (tick && (hold_cnt_q != '1)) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (rel_edge) begin
               state_d  = ST_IDLE;
               new_ev   = 1'b1;
               new_code = EV_REL_LONG;
            end
`ifdef KEY_REPEAT_EN
            else if (rep_cnt_q == REP_TH) begin
               rep_cnt_d = '0;
               new_ev    = 1'b1;
               new_code  = EV_REPEAT;
            end else if (tick && (rep_cnt_q != '1)) begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Single-entry output register: a new event replaces an accepted one,
   // and is dropped (overflow) while an unaccepted event is pending.
   always_comb begin
      ev_valid_d = ev_valid_q;
      ev_code_d  = ev_code_q;
      overflow_d = overflow_q;
      if (new_ev) begin
         if (!ev_valid_q || event_ready) begin
            ev_valid_d = 1'b1;
            ev_code_d  = new_code;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (ev_valid_q && event_ready) begin
         ev_valid_d = 1'b0;
      end
   end

   assign key_d        = key_in;
   assign key_active_d = now_active;

   // key_q resets to the active level so a key held through reset does not
   // look like a fresh press edge.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         key_q        <= C_INPUT_POLARITY;
         key_active_q <= 1'b0;
         state_q      <= ST_IDLE;
         hold_cnt_q   <= '0;
         ev_valid_q   <= 1'b0;
         ev_code_q    <= EV_NONE;
         overflow_q   <= 1'b0;
      end else begin
         key_q        <= key_d;
         key_active_q <= key_active_d;
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         ev_valid_q   <= ev_valid_d;
         ev_code_q    <= ev_code_d;
         overflow_q   <= overflow_d;
      end
   end

   assign event_valid = ev_valid_q;
   assign event_code  = ev_code_q;
   assign key_active  = key_active_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder
//   Directed bench for key_event_decoder with C_TICK_DIV=4, C_LONG_TICKS=3,
//   C_REPEAT_TICKS=2, active-low key. Expectations for REPEAT follow the
//   KEY_REPEAT_EN macro of the build.
module tb_key_event_decoder;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       key_in  = 1'b1;
   logic       event_ready = 1'b1;
   logic       event_valid;
   logic [2:0] event_code;
   logic       key_active;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   key_event_decoder #(
      .C_INPUT_POLARITY (1'b0),
      .C_TICK_DIV       (4),
      .C_LONG_TICKS     (3),
      .C_REPEAT_TICKS   (2),
      .C_CNT_WIDTH      (16)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in),
      .event_valid (event_valid),
      .event_code  (event_code),
      .event_ready (event_ready),
      .key_active  (key_active),
      .overflow    (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         key_in = i[0];
         checks++;
         if (event_valid !== 1'b0 || event_code !== 3'd0 || key_active !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold i=%0d valid=%b code=%0d active=%b ovf=%b expected all 0",
                     i, event_valid, event_code, key_active, overflow);
         end
      end
      // Release reset with the key already held.
      @(negedge sys_clk);
      key_in  = 1'b0;
      @(negedge sys_clk);
      sys_rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge sys_clk);
         checks++;
         if (event_valid !== 1'b0 || key_active !== 1'b1) begin
            errors++;
            $display("FAIL reset_held_key n=%0d valid=%b active=%b expected valid=0 active=1",
                     i, event_valid, key_active);
         end
      end
      key_in = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (event_valid !== 1'b0 || key_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_in_idle valid=%b active=%b expected valid=0 active=0",
                  event_valid, key_active);
      end
      @(negedge sys_clk);
      key_in = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (event_valid !== 1'b1 || event_code !== 3'd1) begin
         errors++;
         $display("FAIL reset_first_press valid=%b code=%0d expected valid=1 code=1",
                  event_valid, event_code);
      end
      @(negedge sys_clk);
      key_in = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (event_valid !== 1'b1 || event_code !== 3'd2) begin
         errors++;
         $display("FAIL reset_first_release valid=%b code=%0d expected valid=1 code=2",
                  event_valid, event_code);
      end
      repeat (6) @(negedge sys_clk);
   endtask

   // Press for hold_len cycles, then watch negedges 1..span after the press.
   task automatic test_short_press();
      logic       exp_v;
      logic [2:0] exp_c;
      key_in = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge sys_clk);
         if (n == 8) key_in = 1'b1;
         exp_v = (n == 1) || (n == 9);
         exp_c = (n == 1) ? 3'd1 : 3'd2;
         checks++;
         if (event_valid !== exp_v || (exp_v && event_code !== exp_c)) begin
            errors++;
            $display("FAIL short n=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     n, event_valid, event_code, exp_v, exp_c);
         end
         if (n == 1 || n == 9) begin
            checks++;
            if (key_active !== (n == 1)) begin
               errors++;
               $display("FAIL short_key_active n=%0d active=%b expected %b", n, key_active, (n == 1));
            end
         end
      end
   endtask

   task automatic test_long_press();
      logic       exp_v;
      logic [2:0] exp_c;
      key_in = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge sys_clk);
         if (n == 30) key_in = 1'b1;
         exp_v = 1'b0;
         exp_c = 3'd0;
         case (n)
            1:  begin exp_v = 1'b1; exp_c = 3'd1; end
            14: begin exp_v = 1'b1; exp_c = 3'd3; end
            31: begin exp_v = 1'b1; exp_c = 3'd4; end
`ifdef KEY_REPEAT_EN
            22: begin exp_v = 1'b1; exp_c = 3'd5; end
            30: begin exp_v = 1'b1; exp_c = 3'd5; end
`endif
            default: ;
         endcase
         checks++;
         if (event_valid !== exp_v || (exp_v && event_code !== exp_c)) begin
            errors++;
            $display("FAIL long n=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     n, event_valid, event_code, exp_v, exp_c);
         end
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL long_overflow ovf=%b expected 0", overflow);
      end
   endtask

   // Release lands on the cycle the hold counter hits the LONG threshold.
   task automatic test_release_at_threshold();
      logic       exp_v;
      logic [2:0] exp_c;
      key_in = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge sys_clk);
         if (n == 13) key_in = 1'b1;
         exp_v = (n == 1) || (n == 14);
         exp_c = (n == 1) ? 3'd1 : 3'd2;
         checks++;
         if (event_valid !== exp_v || (exp_v && event_code !== exp_c)) begin
            errors++;
            $display("FAIL coincident n=%0d valid=%b code=%0d expected valid=%b code=%0d",
                     n, event_valid, event_code, exp_v, exp_c);
         end
      end
      // FSM back in IDLE: a fresh press yields PRESS.
      key_in = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (event_valid !== 1'b1 || event_code !== 3'd1) begin
         errors++;
         $display("FAIL coincident_idle valid=%b code=%0d expected valid=1 code=1",
                  event_valid, event_code);
      end
      @(negedge sys_clk);
      key_in = 1'b1;
      repeat (6) @(negedge sys_clk);
   endtask

   task automatic test_backpressure();
      event_ready = 1'b0;
      key_in = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge sys_clk);
         if (n == 3) key_in = 1'b1;
         checks++;
         if (event_valid !== 1'b1 || event_code !== 3'd1) begin
            errors++;
            $display("FAIL bp_hold n=%0d valid=%b code=%0d expected valid=1 code=1",
                     n, event_valid, event_code);
         end
         checks++;
         if (overflow !== (n >= 4)) begin
            errors++;
            $display("FAIL bp_overflow n=%0d ovf=%b expected %b", n, overflow, (n >= 4));
         end
      end
      event_ready = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge sys_clk);
         checks++;
         if (event_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_accept n=%0d valid=%b ovf=%b expected valid=0 ovf=1",
                     n, event_valid, overflow);
         end
      end
   endtask

   initial begin
      test_reset();
      test_short_press();
      repeat (5) @(negedge sys_clk);
      test_long_press();
      repeat (5) @(negedge sys_clk);
      test_release_at_threshold();
      test_backpressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the clean, debounced level from the dejitter stage (same sys_clk domain) and turns it into timed key events: press, short release, long press, long release and optional auto-repeat.
- Events are presented one at a time on a valid/ready port to the DAC control logic, which uses them to step or commit AD5313R codes.

Parameters:
- C_INPUT_POLARITY, 1'b0: active (pressed) level of key_in. Matches the dejitter stage's polarity.
- C_TICK_DIV, 50000: sys_clk cycles per timing tick (1 ms at 50 MHz). Must be ≥ 2.
- C_LONG_TICKS, 1000: ticks held before a LONG event. Must be ≥ 1.
- C_REPEAT_TICKS, 200: ticks between REPEAT events while long-held. Must be ≥ 1.
- C_CNT_WIDTH, 16: width of the hold and repeat counters. Must hold max(C_LONG_TICKS, C_REPEAT_TICKS).

Ports:
- sys_clk, in, 1: system clock, the only clock.
- sys_rst, in, 1: reset. Asynchronous assert, active-low; the block is in reset while sys_rst = 0.
- key_in, in, 1: debounced key level from the dejitter stage.
- event_valid, out, 1: an event is pending.
- event_code, out, 3: pending event code. 1 = PRESS, 2 = REL_SHORT, 3 = LONG, 4 = REL_LONG, 5 = REPEAT.
- event_ready, in, 1: consumer accepts the event when event_valid & event_ready.
- key_active, out, 1: registered pressed state, 1 = pressed.
- overflow, out, 1: sticky flag; set when an event is dropped.

Behaviour:
- Reset values: event_valid = 0, event_code = 0, key_active = 0, overflow = 0. FSM = IDLE, all counters = 0.
- Reset is honoured mid-press: after release of reset the FSM is in IDLE even if key_in is active. A new PRESS requires an inactive-to-active edge.
- key_in is registered once into key_q. Press edge is key_q inactive and key_in active; release edge is the reverse.
- FSM states:
  - IDLE: on press edge go to PRESSED. Clear the prescaler, hold_cnt and rep_cnt. Emit PRESS.
  - PRESSED: on each tick, hold_cnt increments (saturating). When hold_cnt reaches C_LONG_TICKS, go to LONG_HELD and emit LONG. On release edge, go to IDLE and emit REL_SHORT.
  - LONG_HELD: on release edge, go to IDLE and emit REL_LONG. With KEY_REPEAT_EN, on each tick rep_cnt increments; when it reaches C_REPEAT_TICKS, emit REPEAT and clear rep_cnt.
- Release edge has priority over the LONG/REPEAT threshold in the same cycle: only the release event is emitted.
- Prescaler: counts 0 .. C_TICK_DIV-1 and produces a 1-cycle tick at wrap. It is cleared on press edge, so LONG fires exactly C_LONG_TICKS*C_TICK_DIV cycles after the press edge (±1 cycle).
- Latency: event_valid rises 1 cycle after the edge or threshold cycle. key_active follows key_in with 1 cycle of latency.
- Output register: one entry.
  - event_valid/event_code hold stable until accepted.
  - If accepted and a new event is generated in the same cycle, the new event is loaded and valid stays 1.
  - If valid & !ready and a new event is generated, the new event is dropped and overflow is set.
  - overflow clears only on reset.
- Counters saturate at all-ones. They never wrap.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined: REPEAT events are generated in LONG_HELD as above.
- Undefined: the rep_cnt logic is removed, code 5 is never emitted, and LONG_HELD only waits for release.

Decomposition:
- Package key_event_pkg: event code localparams (EV_PRESS = 3'd1 … EV_REPEAT = 3'd5) and FSM state encodings (IDLE/PRESSED/LONG_HELD, 2 bits).
- One natural sub-module, tick_prescaler: parameter C_TICK_DIV; inputs sys_clk, sys_rst, clr; output tick.

Test Plan (C_TICK_DIV = 4, C_LONG_TICKS = 3, C_REPEAT_TICKS = 2, C_INPUT_POLARITY = 0, event_ready tied 1 unless stated):
- Reset: hold sys_rst = 0 with key_in toggling → all outputs 0. Release with key_in = 0 held → no PRESS until key_in goes 1 then 0.
- Short press: key_in = 0 for 8 cycles → PRESS 1 cycle after the falling edge, then REL_SHORT 1 cycle after the rising edge. No LONG.
- Long press without KEY_REPEAT_EN: hold 20 cycles → PRESS, then LONG 13 cycles after PRESS (12 cycles + 1 latency), then REL_LONG on release. No code 5.
- Long press with KEY_REPEAT_EN: hold 30 cycles → LONG followed by REPEAT every 8 cycles, then REL_LONG on release.
- Backpressure: event_ready = 0 during PRESS and a short release → PRESS held stable, REL_SHORT dropped, overflow = 1 and sticky. Raising ready accepts PRESS.
- Release coincident with the LONG threshold cycle → REL_SHORT only, FSM in IDLE, no LONG emitted.
